// File: rtl/sr_task_queue_ctrl_if.sv
// Scheduler-facing command/response handshake of the task queue controller.
// The scheduler drives the command side, the controller answers on the response side.
interface sr_task_queue_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_tid;
    logic [31:0] cmd_info;
    logic        rsp_valid;
    logic [2:0]  rsp_err;
    logic [3:0]  rsp_tid;
    logic [31:0] rsp_info;

    modport master (
        output cmd_valid, cmd_op, cmd_tid, cmd_info,
        input  cmd_ready, rsp_valid, rsp_err, rsp_tid, rsp_info
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_tid, cmd_info,
        output cmd_ready, rsp_valid, rsp_err, rsp_tid, rsp_info
    );
endinterface

// File: rtl/sr_task_queue_ctrl.sv
// Command front-end for the shift-register task queue: decodes one scheduler
// command into per-cell control vectors, drives them for one cycle, then responds.
module sr_task_queue_ctrl #(
    parameter int DEPTH    = 16,
    parameter int PRIO_LSB = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sr_task_queue_ctrl_if.slave    bus,
    input  logic [DEPTH-1:0][3:0]  q_tid,
    input  logic [DEPTH-1:0][31:0] q_info,
    input  logic [DEPTH-1:0]       q_empty,
    output logic [3:0]             new_task_id,
    output logic [31:0]            new_task_info,
    output logic [DEPTH-1:0]       enqueue,
    output logic [DEPTH-1:0]       dequeue,
    output logic [DEPTH-1:0]       remove,
    output logic [DEPTH-1:0]       que_act,
    output logic [DEPTH-1:0]       que_blk,
    output logic [4:0]             occupancy
);
    localparam logic [2:0] OP_NOP = 3'd0, OP_ENQ = 3'd1, OP_DEQ = 3'd2,
                           OP_REM = 3'd3, OP_ACT = 3'd4, OP_BLK = 3'd5;
    localparam logic [2:0] E_OK = 3'd0, E_FULL = 3'd1, E_EMPTY = 3'd2,
                           E_NOTFOUND = 3'd3, E_DUP = 3'd4, E_ILLEGAL = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_t;

    state_t state, state_nxt;
    logic   alive;
    logic   accept;

    logic [DEPTH-1:0] match, ins_hit, ins_th, rm_th, m_first;
    logic             any_match;

    logic [DEPTH-1:0] enq_d, deq_d, rem_d, act_d, blk_d;
    logic [DEPTH-1:0] enq_q, deq_q, rem_q, act_q, blk_q;
    logic [2:0]       err_d, err_p, rsp_err_q;
    logic [3:0]       tid_d, tid_p, rsp_tid_q;
    logic [31:0]      info_d, info_p, rsp_info_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign match[i]   = ~q_empty[i] & (q_tid[i] == bus.cmd_tid);
        assign ins_hit[i] = q_empty[i] |
                            (q_info[i][PRIO_LSB +: 8] < bus.cmd_info[PRIO_LSB +: 8]);
    end

    // Thermometers from the first insertion point / first match upward.
    always_comb begin
        logic seen_i, seen_m;
        seen_i  = 1'b0;
        seen_m  = 1'b0;
        ins_th  = '0;
        rm_th   = '0;
        m_first = '0;
        for (int i = 0; i < DEPTH; i++) begin
            seen_i     = seen_i | ins_hit[i];
            ins_th[i]  = seen_i;
            m_first[i] = match[i] & ~seen_m;
            seen_m     = seen_m | match[i];
            rm_th[i]   = seen_m;
        end
    end
    assign any_match = |match;

    always_comb begin
        enq_d  = '0;
        deq_d  = '0;
        rem_d  = '0;
        act_d  = '0;
        blk_d  = '0;
        err_d  = E_OK;
        tid_d  = bus.cmd_tid;
        info_d = '0;
        case (bus.cmd_op)
            OP_NOP: ;
            OP_ENQ: begin
                if (~q_empty[DEPTH-1]) err_d = E_FULL;
                else if (any_match)    err_d = E_DUP;
                else                   enq_d = ins_th;
            end
            OP_DEQ: begin
                if (q_empty[0]) err_d = E_EMPTY;
                else begin
                    deq_d  = '1;
                    tid_d  = q_tid[0];
                    info_d = q_info[0];
                end
            end
            OP_REM: if (!any_match) err_d = E_NOTFOUND; else rem_d = rm_th;
            OP_ACT: if (!any_match) err_d = E_NOTFOUND; else act_d = m_first;
            OP_BLK: if (!any_match) err_d = E_NOTFOUND; else blk_d = m_first;
            default: err_d = E_ILLEGAL;
        endcase
    end

    assign accept = bus.cmd_valid & bus.cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            alive <= 1'b0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_RESP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Response fields are staged at acceptance and published on entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {enq_q, deq_q, rem_q, act_q, blk_q} <= '0;
            new_task_id   <= '0;
            new_task_info <= '0;
            err_p         <= E_OK;
            tid_p         <= '0;
            info_p        <= '0;
            rsp_err_q     <= E_OK;
            rsp_tid_q     <= '0;
            rsp_info_q    <= '0;
        end else begin
            if (accept) begin
                {enq_q, deq_q, rem_q, act_q, blk_q} <= {enq_d, deq_d, rem_d, act_d, blk_d};
                new_task_id   <= bus.cmd_tid;
                new_task_info <= bus.cmd_info;
                err_p         <= err_d;
                tid_p         <= tid_d;
                info_p        <= info_d;
            end
            if (state == S_SETTLE) begin
                rsp_err_q  <= err_p;
                rsp_tid_q  <= tid_p;
                rsp_info_q <= info_p;
            end
        end
    end

    always_comb begin
        bus.cmd_ready = alive & (state == S_IDLE);
        bus.rsp_valid = (state == S_RESP);
        bus.rsp_err   = rsp_err_q;
        bus.rsp_tid   = rsp_tid_q;
        bus.rsp_info  = rsp_info_q;
        enqueue       = enq_q & {DEPTH{state == S_ISSUE}};
        dequeue       = deq_q & {DEPTH{state == S_ISSUE}};
        remove        = rem_q & {DEPTH{state == S_ISSUE}};
        que_act       = act_q & {DEPTH{state == S_ISSUE}};
        que_blk       = blk_q & {DEPTH{state == S_ISSUE}};
    end

    always_comb begin
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + 5'(~q_empty[i]);
        occupancy = cnt;
    end
endmodule

// File: doc/sr_task_queue_ctrl.md
# sr_task_queue_ctrl

Command front-end for the 16-cell shift-register task queue. Accepts one scheduler command at a time (enqueue, dequeue, remove, activate, block) over a valid/ready handshake and snoops the queue's per-cell tid, info and empty flags. Translates each command into the per-cell `enqueue`/`dequeue`/`remove`/`que_act`/`que_blk` vectors that drive the queue, then returns a status response. Sits directly upstream of the queue, between the scheduler FSM and the queue array.

## Interface
Parameters:
- `DEPTH`, 16, number of queue cells; only 16 is supported.
- `PRIO_LSB`, 0, LSB of the 8-bit priority field inside `task_info` (bits `PRIO_LSB+7:PRIO_LSB`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller idle; command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  3  0 NOP, 1 ENQ, 2 DEQ, 3 REMOVE, 4 ACT, 5 BLK; 6–7 illegal.
- `cmd_tid`  in  4  target / new task id.
- `cmd_info`  in  32  new task info (ENQ only).
- `q_tid`  in  4×16  `task_tid` from the queue cells.
- `q_info`  in  32×16  `task_info` from the queue cells.
- `q_empty`  in  16  `empty_flag` from the queue cells.
- `new_task_id`  out  4  registered `cmd_tid`.
- `new_task_info`  out  32  registered `cmd_info`.
- `enqueue`, `dequeue`, `remove`, `que_act`, `que_blk`  out  16 each  per-cell controls.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_err`  out  3  0 OK, 1 FULL, 2 EMPTY, 3 NOTFOUND, 4 DUP, 5 ILLEGAL.
- `rsp_tid`  out  4  tid acted on (DEQ: the head tid).
- `rsp_info`  out  32  DEQ: the head info; otherwise 0.
- `occupancy`  out  5  popcount of `~q_empty`; combinational.

## Operation
- Queue invariant: occupied cells are contiguous from cell 0 (head). Cell 0 holds the highest priority.
- `match[i] = ~q_empty[i] & (q_tid[i] == cmd_tid)`. The first match wins.
- ENQ:
  - Errors: FULL if `~q_empty[15]`; otherwise DUP if any match.
  - Insertion point `p` = lowest `i` with `q_empty[i]`, or with prio(`q_info[i]`) < prio(`cmd_info`). The comparison is strict, so equal priorities stay FIFO.
  - `enqueue[i] = (i >= p)`, a thermometer. Cell `p` loads `new_task_*`; cells above `p` shift from their lower neighbour.
- DEQ:
  - Error: EMPTY if `q_empty[0]`.
  - `dequeue = 16'hFFFF`, so all cells shift toward the head.
  - `rsp_tid`/`rsp_info` = cell 0 contents, sampled at acceptance.
- REMOVE:
  - Error: NOTFOUND if no match.
  - `k` = match index; `remove[i] = (i >= k)`, a thermometer.
- ACT / BLK:
  - Error: NOTFOUND if no match.
  - `que_act` or `que_blk` is one-hot at `k`.
- NOP: response OK, all vectors 0.
- On any error, every control vector stays 0 and the queue is untouched.
- FSM states: IDLE → ISSUE → SETTLE → RESP → IDLE.
  - IDLE: `cmd_ready=1`. On accept, register the command, the computed vectors and the response fields; go to ISSUE.
  - ISSUE: control vectors driven for exactly this one cycle.
  - SETTLE: vectors 0; the queue's new state becomes visible.
  - RESP: `rsp_valid=1` for one cycle; return to IDLE.
- Response fields hold their values until the next RESP.

## Timing
- Reset values while `rst_n=0` and after release:
  - State IDLE.
  - All control vectors, `new_task_*`, `rsp_*`: 0.
  - `cmd_ready=0` while `rst_n=0`; it rises in the first cycle after release.
- Latency, with acceptance at edge E0:
  - Vectors high during cycle E0–E1.
  - Queue updated at E1.
  - `rsp_valid` high during cycle E2–E3.
  - `cmd_ready` high again after E3.
- Throughput: one command per 4 cycles.
- `cmd_valid` is ignored outside IDLE; no queuing or back-to-back acceptance.
- All decisions use queue state sampled at the acceptance edge only.
- `new_task_id`/`new_task_info` are stable from E0 through the next acceptance.
- Reset asserted mid-command: the command is dropped, vectors clear immediately and no response is issued. Queue contents are not reset by this block.
- Illegal `cmd_op`: response ILLEGAL, no vectors, same 4-cycle timing.

## Test plan
- ENQ into empty queue, tid 3, prio 5:
  - `enqueue=16'hFFFF`, one cycle.
  - Response OK, `occupancy` 0→1.
- Queue [prio 9, 5, 2]; ENQ tid 7, prio 5:
  - p=2, `enqueue=16'hFFFC`.
  - Resulting order 9, 5, 5(tid 7), 2.
  - Response OK.
- ENQ with 16 occupied → FULL. ENQ of a tid already present → DUP. Both with all vectors 0.
- DEQ with head tid 4, info 32'hA5 → `dequeue=16'hFFFF`, `rsp_tid=4`, `rsp_info=32'hA5`. DEQ on empty → EMPTY, no vectors.
- REMOVE tid 9 at cell 6 → `remove=16'hFFC0`. ACT tid 9 → `que_act=16'h0040`. BLK of absent tid → NOTFOUND.
- Assert `rst_n` low during ISSUE:
  - Vectors drop to 0 asynchronously.
  - No `rsp_valid`.
  - `cmd_ready` returns 1 one cycle after release.
